// File: rtl/sdram_resp_pkg.sv
// Shared definitions for the SDRAM responder: command codes, mode-register
// field positions, burst/CAS decode helpers and error-bit indices.
package sdram_resp_pkg;

  // {ras, cas, we} with cs already known to be low
  typedef enum logic [3:0] {
    CMD_LOAD_MODE = 4'b0000,
    CMD_REFRESH   = 4'b0001,
    CMD_PRECHARGE = 4'b0010,
    CMD_ACTIVE    = 4'b0011,
    CMD_WRITE     = 4'b0100,
    CMD_READ      = 4'b0101,
    CMD_TERMINATE = 4'b0110,
    CMD_NOP       = 4'b0111
  } cmd_e;

  typedef enum logic [1:0] {
    BURST_IDLE,
    BURST_READ,
    BURST_WRITE
  } burst_e;

  localparam int MODE_BL_LSB = 0;
  localparam int MODE_CL_LSB = 4;
  localparam int A_PRE_ALL   = 10;

  localparam int ERR_W        = 7;
  localparam int ERR_CLOSED   = 0;
  localparam int ERR_ACT_OPEN = 1;
  localparam int ERR_RCD      = 2;
  localparam int ERR_RP       = 3;
  localparam int ERR_RFC      = 4;
  localparam int ERR_REF_OPEN = 5;
  localparam int ERR_NO_MODE  = 6;

  // Burst length kept as a wrap mask (BL-1); unsupported codes fall back to BL=1.
  function automatic logic [2:0] bl_mask_decode(input logic [2:0] code);
    case (code)
      3'd1:    return 3'd1;
      3'd2:    return 3'd3;
      3'd3:    return 3'd7;
      default: return 3'd0;
    endcase
  endfunction

  // Only CL=3 is distinguished; every other code behaves as CL=2.
  function automatic logic cl3_decode(input logic [2:0] code);
    return code == 3'd3;
  endfunction

endpackage

// File: rtl/sdram_responder_if.sv
// SDRAM command/data bus between controller (master) and device model (slave).
interface sdram_responder_if #(
  parameter int DATA_W = 32
);
  logic              sdram_cle;
  logic              sdram_cs;
  logic              sdram_ras;
  logic              sdram_cas;
  logic              sdram_we;
  logic              sdram_dqm;
  logic [1:0]        sdram_ba;
  logic [12:0]       sdram_a;
  logic [DATA_W-1:0] dq_in;
  logic [DATA_W-1:0] dq_out;
  logic              dq_out_en;

  modport master (
    output sdram_cle, sdram_cs, sdram_ras, sdram_cas, sdram_we, sdram_dqm,
    output sdram_ba, sdram_a, dq_in,
    input  dq_out, dq_out_en
  );

  modport slave (
    input  sdram_cle, sdram_cs, sdram_ras, sdram_cas, sdram_we, sdram_dqm,
    input  sdram_ba, sdram_a, dq_in,
    output dq_out, dq_out_en
  );
endinterface

// File: rtl/sdram_resp_bank_tracker.sv
// Per-bank state: open flag, open row and (with SDRAM_RESP_TIMING_CHECK_EN)
// edge counters since the last ACTIVE / PRECHARGE for tRCD and tRP checks.
module sdram_resp_bank_tracker #(
  parameter int ROW_W = 4,
  parameter int T_RCD = 3,
  parameter int T_RP  = 3
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             activate,
  input  logic             precharge,
  input  logic [ROW_W-1:0] row_in,
  output logic             is_open,
  output logic [ROW_W-1:0] row,
  output logic             rcd_ok,
  output logic             rp_ok
);

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples the pre-edge values regardless of block ordering.
  always_ff @(posedge clk) begin
    if (rst) begin
      is_open <= 1'b0;
      row     <= '0;
    end else if (activate) begin
      is_open <= 1'b1;
      row     <= row_in;
    end else if (precharge) begin
      is_open <= 1'b0;
    end
  end

`ifdef SDRAM_RESP_TIMING_CHECK_EN
  localparam int CNT_W = $clog2(T_RCD + T_RP + 2);

  logic [CNT_W-1:0] rcd_cnt;
  logic [CNT_W-1:0] rp_cnt;

  // Counters hold the number of edges since the command, saturating once legal.
  always_ff @(posedge clk) begin
    if (rst) begin
      rcd_cnt <= CNT_W'(T_RCD);
      rp_cnt  <= CNT_W'(T_RP);
    end else begin
      if (activate)                      rcd_cnt <= CNT_W'(1);
      else if (rcd_cnt < CNT_W'(T_RCD))  rcd_cnt <= rcd_cnt + 1'b1;
      if (precharge)                     rp_cnt  <= CNT_W'(1);
      else if (rp_cnt < CNT_W'(T_RP))    rp_cnt  <= rp_cnt + 1'b1;
    end
  end

  assign rcd_ok = rcd_cnt >= CNT_W'(T_RCD);
  assign rp_ok  = rp_cnt  >= CNT_W'(T_RP);
`else
  assign rcd_ok = 1'b1;
  assign rp_ok  = 1'b1;
`endif

endmodule

// File: rtl/sdram_responder.sv
// SDRAM device model: command decode, mode register, burst/CAS pipeline,
// backing store and sticky violation flags. SDRAM_RESP_TIMING_CHECK_EN enables err[4:2].
module sdram_responder
  import sdram_resp_pkg::*;
#(
  parameter int ROW_W  = 4,
  parameter int COL_W  = 8,
  parameter int DATA_W = 32,
  parameter int T_RCD  = 3,
  parameter int T_RP   = 3,
  parameter int T_RFC  = 7
) (
  input  logic             clk,
  input  logic             rst,
  sdram_responder_if.slave bus,
  output logic [ERR_W-1:0] err,
  output logic             mode_loaded
);

  localparam int ADDR_W = 2 + ROW_W + COL_W;

  typedef struct packed {
    logic              valid;
    logic [ADDR_W-1:0] addr;
  } slot_t;

  // ---------------- command decode ----------------
  cmd_e       cmd;
  logic       cmd_valid;
  logic       is_act, is_read, is_write, is_term, is_pre, is_ref, is_lmr;
  logic [1:0] ba;
  logic       unused_a;

  assign cmd_valid = bus.sdram_cle && !bus.sdram_cs;
  assign cmd       = cmd_e'({1'b0, bus.sdram_ras, bus.sdram_cas, bus.sdram_we});
  assign ba        = bus.sdram_ba;
  assign is_act    = cmd_valid && cmd == CMD_ACTIVE;
  assign is_read   = cmd_valid && cmd == CMD_READ;
  assign is_write  = cmd_valid && cmd == CMD_WRITE;
  assign is_term   = cmd_valid && cmd == CMD_TERMINATE;
  assign is_pre    = cmd_valid && cmd == CMD_PRECHARGE;
  assign is_ref    = cmd_valid && cmd == CMD_REFRESH;
  assign is_lmr    = cmd_valid && cmd == CMD_LOAD_MODE;
  assign unused_a  = ^bus.sdram_a;

  // ---------------- bank trackers ----------------
  logic [3:0]       bank_open, rcd_ok, rp_ok;
  logic [ROW_W-1:0] bank_row [4];

  for (genvar g = 0; g < 4; g++) begin : g_bank
    sdram_resp_bank_tracker #(
      .ROW_W(ROW_W), .T_RCD(T_RCD), .T_RP(T_RP)
    ) u_tracker (
      .clk      (clk),
      .rst      (rst),
      .activate (is_act && ba == 2'(g)),
      .precharge(is_pre && (bus.sdram_a[A_PRE_ALL] || ba == 2'(g))),
      .row_in   (bus.sdram_a[ROW_W-1:0]),
      .is_open  (bank_open[g]),
      .row      (bank_row[g]),
      .rcd_ok   (rcd_ok[g]),
      .rp_ok    (rp_ok[g])
    );
  end

  logic             sel_open;
  logic [ROW_W-1:0] sel_row;
  logic             rw_ok;

  assign sel_open = bank_open[ba];
  assign sel_row  = bank_row[ba];
  assign rw_ok    = (is_read || is_write) && sel_open;

  // ---------------- refresh timing ----------------
  logic rfc_ok;
`ifdef SDRAM_RESP_TIMING_CHECK_EN
  localparam int RFC_W = $clog2(T_RFC + 2);
  logic [RFC_W-1:0] rfc_cnt;

  always_ff @(posedge clk) begin
    if (rst)                           rfc_cnt <= RFC_W'(T_RFC);
    else if (is_ref)                   rfc_cnt <= RFC_W'(1);
    else if (rfc_cnt < RFC_W'(T_RFC))  rfc_cnt <= rfc_cnt + 1'b1;
  end

  assign rfc_ok = rfc_cnt >= RFC_W'(T_RFC);
`else
  assign rfc_ok = 1'b1;
`endif

  // ---------------- mode register ----------------
  logic [2:0] bl_mask;
  logic       cl3;

  always_ff @(posedge clk) begin
    if (rst) begin
      bl_mask     <= 3'd0;
      cl3         <= 1'b0;
      mode_loaded <= 1'b0;
    end else if (is_lmr) begin
      bl_mask     <= bl_mask_decode(bus.sdram_a[MODE_BL_LSB +: 3]);
      cl3         <= cl3_decode(bus.sdram_a[MODE_CL_LSB +: 3]);
      mode_loaded <= 1'b1;
    end
  end

  // ---------------- violation flags ----------------
  logic [ERR_W-1:0] err_set;

  always_comb begin
    err_set               = '0;
    err_set[ERR_CLOSED]   = (is_read || is_write) && !sel_open;
    err_set[ERR_ACT_OPEN] = is_act && sel_open;
    err_set[ERR_RCD]      = rw_ok && !rcd_ok[ba];
    err_set[ERR_RP]       = (is_act && !rp_ok[ba]) || (is_ref && !(&rp_ok));
    err_set[ERR_RFC]      = cmd_valid && cmd != CMD_NOP && !rfc_ok;
    err_set[ERR_REF_OPEN] = is_ref && |bank_open;
    err_set[ERR_NO_MODE]  = !mode_loaded && (is_act || is_read || is_write || is_term);
  end

  always_ff @(posedge clk) begin
    if (rst) err <= '0;
    else     err <= err | err_set;
  end

  // ---------------- burst engine ----------------
  burst_e           burst_state;
  logic [2:0]       burst_rem;
  logic [1:0]       burst_bank;
  logic [ROW_W-1:0] burst_row;
  logic [COL_W-1:0] burst_col;
  logic [COL_W-1:0] col_mask, next_col;
  logic             truncate;
  logic             issue_valid, issue_write;
  logic [ADDR_W-1:0] issue_addr;

  // Column advances inside the BL-aligned block and wraps at its end.
  assign col_mask = COL_W'(bl_mask);
  assign next_col = (burst_col & ~col_mask) | ((burst_col + 1'b1) & col_mask);
  assign truncate = is_term ||
                    (is_pre && (bus.sdram_a[A_PRE_ALL] || ba == burst_bank));

  // NOTE: every output gets a default before the branches so no latch is inferred.
  always_comb begin
    issue_valid = 1'b0;
    issue_write = 1'b0;
    issue_addr  = '0;
    if (rw_ok) begin
      issue_valid = 1'b1;
      issue_write = is_write;
      issue_addr  = {ba, sel_row, bus.sdram_a[COL_W-1:0]};
    end else if (burst_state != BURST_IDLE && !truncate) begin
      issue_valid = 1'b1;
      issue_write = burst_state == BURST_WRITE;
      issue_addr  = {burst_bank, burst_row, next_col};
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      burst_state <= BURST_IDLE;
      burst_rem   <= 3'd0;
      burst_bank  <= 2'd0;
      burst_row   <= '0;
      burst_col   <= '0;
    end else if (rw_ok) begin
      burst_state <= (bl_mask == 3'd0) ? BURST_IDLE : (is_write ? BURST_WRITE : BURST_READ);
      burst_rem   <= bl_mask;
      burst_bank  <= ba;
      burst_row   <= sel_row;
      burst_col   <= bus.sdram_a[COL_W-1:0];
    end else if (truncate) begin
      burst_state <= BURST_IDLE;
      burst_rem   <= 3'd0;
    end else if (burst_state != BURST_IDLE) begin
      burst_rem <= burst_rem - 1'b1;
      burst_col <= next_col;
      if (burst_rem == 3'd1) burst_state <= BURST_IDLE;
    end
  end

  // ---------------- backing store ----------------
  logic [DATA_W-1:0] mem [1 << ADDR_W];

  // NOTE: the store is deliberately not reset; only control state is cleared,
  // which keeps the array mappable onto plain RAM.
  always_ff @(posedge clk) begin
    if (!rst && issue_valid && issue_write && !bus.sdram_dqm)
      mem[issue_addr] <= bus.dq_in;
  end

  // ---------------- CAS-latency pipeline ----------------
  slot_t pipe [3];
  slot_t out_slot;
  logic  dqm_d1, dqm_d2;

  always_ff @(posedge clk) begin
    if (rst) begin
      pipe[0] <= '0;
      pipe[1] <= '0;
      pipe[2] <= '0;
      dqm_d1  <= 1'b0;
      dqm_d2  <= 1'b0;
    end else begin
      pipe[0] <= '{valid: issue_valid && !issue_write, addr: issue_addr};
      pipe[1] <= pipe[0];
      pipe[2] <= pipe[1];
      dqm_d1  <= bus.sdram_dqm;
      dqm_d2  <= dqm_d1;
    end
  end

  // Slot issued at edge N sits in pipe[CL-1] just before edge N+CL.
  assign out_slot = cl3 ? pipe[2] : pipe[1];

  always_ff @(posedge clk) begin
    if (rst) begin
      bus.dq_out    <= '0;
      bus.dq_out_en <= 1'b0;
    end else begin
      bus.dq_out_en <= out_slot.valid && !dqm_d2;
      if (out_slot.valid) bus.dq_out <= mem[out_slot.addr];
    end
  end

endmodule

// File: tb/tb_sdram_responder.sv
// Self-checking bench for sdram_responder: a scoreboard queue of expected read
// words (value and arrival edge) plus direct checks of the sticky error flags.
module tb_sdram_responder;
  import sdram_resp_pkg::*;

`ifdef SDRAM_RESP_TIMING_CHECK_EN
  localparam bit TCHK = 1'b1;
`else
  localparam bit TCHK = 1'b0;
`endif

  logic       clk = 1'b0;
  logic       rst;
  logic [6:0] err;
  logic       mode_loaded;

  always #5 clk = ~clk;

  sdram_responder_if #(.DATA_W(32)) bus ();

  sdram_responder #(
    .ROW_W(4), .COL_W(8), .DATA_W(32), .T_RCD(3), .T_RP(3), .T_RFC(7)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .bus        (bus),
    .err        (err),
    .mode_loaded(mode_loaded)
  );

  typedef struct {
    int          at_edge;
    logic [31:0] data;
  } exp_t;

  exp_t        sb [$];
  logic [31:0] model [int];
  int          open_row [4];
  int          cur_bl = 1;
  int          cur_cl = 2;
  int          total  = 0;
  int          bad    = 0;
  int          cyc    = 0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%h exp=%h (edge %0d)", tag, got, exp, cyc);
    end
  endtask

  // Outputs are sampled on the falling edge, halfway between updates.
  always @(negedge clk) begin
    exp_t e;
    if (bus.dq_out_en === 1'b1) begin
      if (sb.size() == 0) begin
        check("rd_unexp", 32'(bus.dq_out_en), 32'd0);
      end else begin
        e = sb.pop_front();
        check("rd_edge", cyc, e.at_edge);
        check("rd_data", bus.dq_out, e.data);
      end
    end
  end

  function automatic int key(input int ba, input int row, input int col);
    return (ba << 12) | ((row & 15) << 8) | (col & 255);
  endfunction

  function automatic int wrapc(input int col, input int i);
    int m = cur_bl - 1;
    return (col & ~m) | ((col + i) & m);
  endfunction

  task automatic drive(input logic [3:0] c, input logic [1:0] ba, input logic [12:0] a,
                       input logic [31:0] d, input logic dqm);
    {bus.sdram_cs, bus.sdram_ras, bus.sdram_cas, bus.sdram_we} = c;
    bus.sdram_ba  = ba;
    bus.sdram_a   = a;
    bus.dq_in     = d;
    bus.sdram_dqm = dqm;
    @(negedge clk);
  endtask

  task automatic nop(input int n);
    for (int i = 0; i < n; i++) drive(CMD_NOP, 2'd0, 13'd0, 32'd0, 1'b0);
  endtask

  task automatic lmr(input logic [12:0] a);
    drive(CMD_LOAD_MODE, 2'd0, a, 32'd0, 1'b0);
    case (a[2:0])
      3'd1:    cur_bl = 2;
      3'd2:    cur_bl = 4;
      3'd3:    cur_bl = 8;
      default: cur_bl = 1;
    endcase
    cur_cl = (a[6:4] == 3'd3) ? 3 : 2;
  endtask

  task automatic act(input int ba, input int row);
    drive(CMD_ACTIVE, 2'(ba), 13'(row), 32'd0, 1'b0);
    open_row[ba] = row;
  endtask

  // Write burst of base, base+1, ...; msk bit i drops word i.
  task automatic wr(input int ba, input int col, input logic [31:0] base, input logic [7:0] msk);
    for (int i = 0; i < cur_bl; i++) begin
      drive((i == 0) ? CMD_WRITE : CMD_NOP, 2'(ba), 13'(col), base + 32'(i), msk[i]);
      if (!msk[i]) model[key(ba, open_row[ba], wrapc(col, i))] = base + 32'(i);
    end
  endtask

  // READ with the first nwords words expected, word 'skip' masked (-1 = none).
  task automatic rd(input int ba, input int col, input int nwords, input int skip);
    int   n = cyc + 1;
    exp_t e;
    drive(CMD_READ, 2'(ba), 13'(col), 32'd0, 1'b0);
    for (int i = 0; i < nwords; i++) begin
      if (i != skip) begin
        e.at_edge = n + cur_cl + i;
        e.data    = model[key(ba, open_row[ba], wrapc(col, i))];
        sb.push_back(e);
      end
    end
  endtask

  task automatic drain();
    for (int i = 0; i < 16 && sb.size() > 0; i++) nop(1);
    nop(2);
    check("drain", sb.size(), 32'd0);
  endtask

  task automatic do_reset();
    rst = 1'b1;
    nop(1);
    rst = 1'b0;
    sb.delete();
    cur_bl = 1;
    cur_cl = 2;
  endtask

  initial begin
    rst           = 1'b1;
    bus.sdram_cle = 1'b1;
    {bus.sdram_cs, bus.sdram_ras, bus.sdram_cas, bus.sdram_we} = CMD_NOP;
    bus.sdram_ba  = 2'd0;
    bus.sdram_a   = 13'd0;
    bus.dq_in     = 32'd0;
    bus.sdram_dqm = 1'b0;
    repeat (2) @(negedge clk);
    rst = 1'b0;

    check("rst_err", 32'(err), 32'd0);
    check("rst_mode", 32'(mode_loaded), 32'd0);
    check("rst_en", 32'(bus.dq_out_en), 32'd0);
    check("rst_dq", bus.dq_out, 32'd0);

    // READ before LOAD_MODE, bank also closed
    drive(CMD_READ, 2'd0, 13'h010, 32'd0, 1'b0);
    nop(3);
    check("err_nomode", 32'(err), 32'h41);
    do_reset();
    check("err_after_rst", 32'(err), 32'd0);

    lmr(13'h022);
    check("mode_loaded", 32'(mode_loaded), 32'd1);

    act(0, 5);
    nop(2);
    wr(0, 'h10, 32'hA5A5_0001, 8'h00);
    rd(0, 'h10, 4, -1);
    drain();
    rd(0, 'h13, 4, -1);
    drain();

    // back-to-back READs: first burst truncated after one word
    rd(0, 'h10, 1, -1);
    rd(0, 'h12, 4, -1);
    drain();

    // read dqm one edge after READ masks the second word
    rd(0, 'h10, 4, 1);
    drive(CMD_NOP, 2'd0, 13'd0, 32'd0, 1'b1);
    drain();

    // write mask keeps the earlier word at col 0x21
    wr(0, 'h20, 32'hB000_0001, 8'h00);
    wr(0, 'h20, 32'hC000_0001, 8'h02);
    rd(0, 'h20, 4, -1);
    drain();
    check("err_clean", 32'(err), 32'd0);

    // CL=3, BL=2
    lmr(13'h031);
    rd(0, 'h11, 2, -1);
    drain();

    // tRCD violation: data still returned
    do_reset();
    lmr(13'h022);
    act(1, 3);
    nop(2);
    wr(1, 0, 32'hD000_0001, 8'h00);
    drive(CMD_PRECHARGE, 2'd1, 13'd0, 32'd0, 1'b0);
    nop(2);
    act(1, 3);
    nop(1);
    rd(1, 0, 4, -1);
    drain();
    check("err_rcd", 32'(err), TCHK ? 32'h04 : 32'h00);

    // READ to closed bank is flagged and ignored
    drive(CMD_READ, 2'd2, 13'h005, 32'd0, 1'b0);
    nop(4);
    check("err_closed", 32'(err), TCHK ? 32'h05 : 32'h01);

    // reset in the middle of a burst
    rd(1, 0, 1, -1);
    nop(2);
    rst = 1'b1;
    nop(1);
    check("rst_mid_en", 32'(bus.dq_out_en), 32'd0);
    check("rst_mid_err", 32'(err), 32'd0);
    check("rst_mid_mode", 32'(mode_loaded), 32'd0);
    rst = 1'b0;
    sb.delete();
    cur_bl = 1;
    cur_cl = 2;
    nop(4);

    // REFRESH with a bank open, then tRFC / tRP / ACTIVE-on-open
    lmr(13'h022);
    act(1, 2);
    nop(2);
    drive(CMD_REFRESH, 2'd0, 13'd0, 32'd0, 1'b0);
    check("err_ref_open", 32'(err), 32'h20);
    nop(1);
    drive(CMD_PRECHARGE, 2'd0, 13'h400, 32'd0, 1'b0);
    act(0, 1);
    nop(2);
    act(0, 1);
    check("err_final", 32'(err), TCHK ? 32'h3A : 32'h22);

    nop(4);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
